// File: rtl/cr16_mem_pkg.sv
// Shared definitions for the CR16 store path: FSM encoding, byte lane selectors and lane width.
package cr16_mem_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD    = 2'd1,
      MERGE = 2'd2,
      WR    = 2'd3
   } state_e;

   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;

endpackage

// File: rtl/byte_lane_merge.sv
// Inserts a byte into one lane of a 16-bit word and flags when the source
// register value does not fit in a byte under the selected signedness.
module byte_lane_merge
   import cr16_mem_pkg::*;
(
   input  logic [15:0]       old_word,
   input  logic [BYTE_W-1:0] new_byte,
   input  logic              lane,
   input  logic              signed_mode,
   input  logic [15:0]       full_data,
   output logic [15:0]       merged,
   output logic              ovf
);

   always_comb begin
      merged = old_word;
      if (lane == LANE_HI) begin
         merged[15:8] = new_byte;
      end else begin
         merged[7:0]  = new_byte;
      end
   end

   // Signed fits when the upper byte replicates bit 7; unsigned fits when it is zero.
   always_comb begin
      if (signed_mode) begin
         ovf = (full_data[15:8] != {BYTE_W{full_data[7]}});
      end else begin
         ovf = (full_data[15:8] != 8'h00);
      end
   end

endmodule

// File: rtl/byte_store_unit.sv
// Store unit for the CR16 datapath: word stores write directly, byte stores
// read-modify-write the addressed lane of a 16-bit word memory.
module byte_store_unit
   import cr16_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   input  logic              st_byte,
   input  logic              st_signed,
   output logic [ADDR_W-2:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              done,
   output logic              ovf,
   output logic              misalign
);

   state_e              state_q, state_d;
   logic                st_ready_q;
   logic                mem_we_q;
   logic                done_q;
   logic                ovf_q;
   logic                misalign_q;
   logic [ADDR_W-2:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [DATA_W-1:0]   data_q;
   logic                signed_q;
   logic                lane_q;
   logic                accept;
   logic [DATA_W-1:0]   merged;
   logic                merge_ovf;

   assign accept = st_valid && st_ready_q;

   byte_lane_merge u_merge (
      .old_word    (mem_rdata),
      .new_byte    (data_q[BYTE_W-1:0]),
      .lane        (lane_q),
      .signed_mode (signed_q),
      .full_data   (data_q),
      .merged      (merged),
      .ovf         (merge_ovf)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = st_byte ? RD : WR;
         RD:      state_d = MERGE;
         MERGE:   state_d = WR;
         WR:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake and write strobes are registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         st_ready_q  <= 1'b1;
         mem_we_q    <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         misalign_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         data_q      <= '0;
         signed_q    <= 1'b0;
         lane_q      <= LANE_LO;
      end else begin
         state_q    <= state_d;
         st_ready_q <= (state_d == IDLE);
         mem_we_q   <= (state_d == WR);
         done_q     <= (state_d == WR);
         if (accept) begin
            mem_addr_q <= st_addr[ADDR_W-1:1];
            data_q     <= st_data;
            signed_q   <= st_signed;
            lane_q     <= st_addr[0];
            ovf_q      <= 1'b0;
            misalign_q <= !st_byte && st_addr[0];
            if (!st_byte) begin
               mem_wdata_q <= st_data;
            end
         end
         if (state_q == MERGE) begin
            mem_wdata_q <= merged;
            ovf_q       <= merge_ovf;
         end
      end
   end

   assign st_ready  = st_ready_q;
   assign mem_we    = mem_we_q;
   assign done      = done_q;
   assign ovf       = ovf_q;
   assign misalign  = misalign_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/byte_store_unit.md
Name: byte_store_unit

Overview:
- Write-side counterpart of the load path's byte sign/zero extension in the CR16 datapath.
- Takes store requests from the core and writes them into a single-port 16-bit word memory (1-cycle read latency).
- Word stores are written directly. Byte stores narrow the register value to 8 bits, flag overflow, and do a read-modify-write into the addressed lane.

Parameters:
- ADDR_W, 16, byte-address width; memory word address is ADDR_W-1 bits.
- DATA_W, 16, memory and register data width; fixed at 16, byte lane is 8.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- st_valid  input  1  store request valid
- st_ready  output  1  unit can accept a request; high only in IDLE
- st_addr  input  ADDR_W  byte address; bit 0 selects lane (0 = [7:0], 1 = [15:8], little-endian)
- st_data  input  16  register value to store
- st_byte  input  1  1 = byte store, 0 = word store
- st_signed  input  1  byte overflow check mode: 1 = signed, 0 = unsigned
- mem_addr  output  ADDR_W-1  word address = latched st_addr[ADDR_W-1:1]
- mem_we  output  1  memory write enable, one-cycle pulse
- mem_wdata  output  16  write data
- mem_rdata  input  16  read data, valid the cycle after mem_addr is presented with mem_we=0
- done  output  1  one-cycle pulse, coincident with mem_we
- ovf  output  1  narrowing overflow of last byte store; valid from done, held until next accept
- misalign  output  1  last word store had st_addr[0]=1; same timing as ovf

Behaviour:
- Reset (rst_n=0 at edge): state IDLE, st_ready=1, mem_we=0, done=0, ovf=0, misalign=0, mem_addr=0, mem_wdata=0, latched request cleared.
- Reset mid-operation aborts the access; no write is issued after reset.
- States: IDLE, RD, MERGE, WR.
- Accept when st_valid && st_ready at an edge. addr, data, byte, signed are latched at accept; later input changes are ignored.
- st_valid while busy: st_ready=0, request is not consumed and the requester holds it.
- Word store: IDLE -> WR.
  - WR cycle: mem_we=1, mem_wdata=data, done=1, then IDLE.
  - Latency is 1 cycle after accept; st_ready returns the following cycle.
  - Address bit 0 is ignored (word-aligned write) and misalign=1.
- Byte store: IDLE -> RD -> MERGE -> WR -> IDLE.
  - RD: mem_addr driven, mem_we=0.
  - MERGE: mem_rdata is valid; the merged word is registered. Lane 0 = {rdata[15:8], data[7:0]}; lane 1 = {data[7:0], rdata[7:0]}.
  - WR: mem_we=1, done=1.
  - Latency is 3 cycles after accept.
- Overflow, computed at accept, byte stores only:
  - signed: ovf=1 if data[15:8] != {8{data[7]}}
  - unsigned: ovf=1 if data[15:8] != 8'h00
  - The store still writes the truncated data[7:0]; ovf never blocks the write.
  - Word stores give ovf=0.
- mem_addr is held stable from RD through WR.
- mem_we is asserted only in WR.
- Back-to-back: a new request may be accepted in the cycle after WR. No overlap, no bypass.

Decomposition:
- Shared package cr16_mem_pkg:
  - state encoding constants (IDLE=2'd0, RD=2'd1, MERGE=2'd2, WR=2'd3)
  - LANE_LO/LANE_HI constants
  - BYTE_W=8
- One combinational sub-module, byte_lane_merge: inputs old_word, new_byte, lane, signed_mode, full_data; outputs merged word and ovf.

Test Plan:
- Word store, addr 0x0010, data 0xBEEF -> 1 cycle later mem_we=1, mem_addr=0x0008, mem_wdata=0xBEEF, done=1, ovf=0, misalign=0.
- Byte store lane 0, addr 0x0020, data 0x0055, signed, memory holds 0x1234 -> RD, MERGE, then WR with mem_wdata=0x1255, done at accept+3, ovf=0.
- Byte store lane 1, addr 0x0021, data 0xFF80, signed, memory holds 0x1234 -> mem_wdata=0x8034, ovf=0.
- Byte store, data 0x0180: signed -> ovf=1; unsigned with data 0x0100 -> ovf=1. Low byte is still written in both cases.
- Word store to addr 0x0031 -> write to word 0x0018, misalign=1; st_valid held during a byte store -> st_ready=0 and no second accept until IDLE.
- rst_n=0 asserted in MERGE -> next cycle IDLE, mem_we never pulses, all outputs at reset values.
